// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register with flush, bubble insertion and
// saturating flush/stall counters. in_ready is registered to break the out_ready path.
module pipe_stage_reg #(
    parameter int                CTRL_W     = 8,
    parameter int                DATA_W     = 128,
    parameter logic [CTRL_W-1:0] FLUSH_CTRL = '0,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              in_hs;
    logic              out_hs;

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    // MAIN lives directly in the out_* registers; SKID only fills when the
    // consumer stalls in the same cycle a new beat is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_ctrl  <= FLUSH_CTRL;
            out_data  <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_ctrl  <= FLUSH_CTRL;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_hs) begin
                        state     <= ONE;
                        out_valid <= 1'b1;
                        out_ctrl  <= in_ctrl;
                        out_data  <= in_data;
                    end
                end
                ONE: begin
                    if (in_hs && out_hs) begin
                        out_ctrl <= in_ctrl;
                        out_data <= in_data;
                    end else if (in_hs) begin
                        state     <= FULL;
                        in_ready  <= 1'b0;
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                    end else if (out_hs) begin
                        // Drained: present a bubble, keep the last data word.
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        out_ctrl  <= FLUSH_CTRL;
                    end
                end
                FULL: begin
                    if (out_hs) begin
                        state    <= ONE;
                        in_ready <= 1'b1;
                        out_ctrl <= skid_ctrl;
                        out_data <= skid_data;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    out_ctrl  <= FLUSH_CTRL;
                end
            endcase
        end
    end

    // A flush cycle never counts as a stall, even with a stalled beat held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            flush_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
            if (!flush && out_valid && !out_ready && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
        end
    end

endmodule
